// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer.
//
// Sits between a multi-cycle instruction memory and the fetch/decode
// pipeline register. Owns the sequential fetch PC, issues one outstanding
// req/ack read at a time, and queues each returned word with its PC in a
// small FIFO. A redirect flushes the FIFO and restarts fetch at the target.
// Any response still in flight for the old path is dropped.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   redirect_i       execute-stage redirect (taken branch / jump)
//   redirect_pc_i    redirect target (low two bits ignored)
//   mem_req_o        read request, high while a read is outstanding
//   mem_addr_o       word-aligned read address, stable until ack
//   mem_ack_i        one-cycle response strobe, mem_data_i valid with it
//   mem_data_i       returned instruction word
//   instr_o, pc_o    head-of-FIFO instruction and its PC (0 when empty)
//   pc_plus4_o       pc_o + 4, wrapping
//   valid_o          FIFO not empty
//   ready_i          consumer takes the head entry this cycle
module instr_prefetch_buffer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  mem_req_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    // IDLE: nothing outstanding. REQ: outstanding, response kept.
    // DISCARD: outstanding, response belongs to a flushed path.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   fetch_pc_q;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [CNT_W-1:0]        count_q;
    logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
    logic [DATA_WIDTH-1:0]   instr_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   pc_mem    [DEPTH];

    logic [DATA_WIDTH-1:0]   target_pc;
    logic [DATA_WIDTH-1:0]   next_addr;
    logic                    push, pop;
    logic                    start_idle, chain;
    logic [CNT_W-1:0]        count_nxt;

    assign target_pc = redirect_pc_i & ALIGN_MASK;
    assign next_addr = addr_q + PC_STEP;

    // A response is kept only in REQ and only when no redirect flushes it.
    assign push = (state_q == ST_REQ) & mem_ack_i & ~redirect_i;
    assign pop  = valid_o & ready_i & ~redirect_i;

    assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);

    // Issuing reserves a FIFO slot for the response, so a request only
    // goes out while the FIFO (after this cycle's push/pop) has room.
    assign start_idle = (state_q == ST_IDLE) & ~redirect_i & (count_q < DEPTH_C);
    assign chain      = push & (count_nxt < DEPTH_C);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_idle) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (mem_ack_i) begin
                    state_d = chain ? ST_REQ : ST_IDLE;
                end else if (redirect_i) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (mem_ack_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_req_o = (state_q == ST_REQ) || (state_q == ST_DISCARD);
    end

    // Fetch PC, request address, FIFO bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            if (redirect_i) begin
                fetch_pc_q <= target_pc;
            end else if (push) begin
                fetch_pc_q <= next_addr;
            end

            if (start_idle) begin
                addr_q <= fetch_pc_q;
            end else if (chain) begin
                addr_q <= next_addr;
            end

            if (redirect_i) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                count_q <= count_nxt;
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage carries no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= mem_data_i;
            pc_mem[wr_ptr_q]    <= addr_q;
        end
    end

    assign mem_addr_o = addr_q;
    assign valid_o    = (count_q != '0);
    assign instr_o    = valid_o ? instr_mem[rd_ptr_q] : '0;
    assign pc_o       = valid_o ? pc_mem[rd_ptr_q]    : '0;
    assign pc_plus4_o = pc_o + PC_STEP;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: directed scenarios on a default-parameter
// instance plus a wrap/async-reset scenario on a RESET_PC=0xFFFF_FFF8 one.
module tb_instr_prefetch_buffer;

    logic        clk;
    logic        rst_n, rst_w_n;

    logic        redirect, ready, mem_req, mem_ack, valid;
    logic [31:0] redirect_pc, mem_addr, mem_data, instr, pc, pc_plus4;

    logic        redirect_w, ready_w, mem_req_w, mem_ack_w, valid_w;
    logic [31:0] redirect_pc_w, mem_addr_w, mem_data_w, instr_w, pc_w, pc_plus4_w;

    int          total = 0;
    int          bad   = 0;

    // Memory content: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    instr_prefetch_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_ack_i(mem_ack), .mem_data_i(mem_data),
        .instr_o(instr), .pc_o(pc), .pc_plus4_o(pc_plus4),
        .valid_o(valid), .ready_i(ready)
    );

    instr_prefetch_buffer #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst_n(rst_w_n),
        .redirect_i(redirect_w), .redirect_pc_i(redirect_pc_w),
        .mem_req_o(mem_req_w), .mem_addr_o(mem_addr_w),
        .mem_ack_i(mem_ack_w), .mem_data_i(mem_data_w),
        .instr_o(instr_w), .pc_o(pc_w), .pc_plus4_o(pc_plus4_w),
        .valid_o(valid_w), .ready_i(ready_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory for the main instance: acks when the request has been up for
    // lat extra cycles (lat=0 acks in the request cycle); ack_force injects
    // a stray strobe.
    int          lat = 0;
    logic        ack_force = 1'b0;
    logic [3:0]  wait_cnt;
    int          ack_cnt = 0;
    logic [31:0] last_ack_addr;

    assign mem_ack  = (mem_req && (wait_cnt == 4'(lat))) || ack_force;
    assign mem_data = mem_word(mem_addr);

    always_ff @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 4'd0;
        else                     wait_cnt <= wait_cnt + 4'd1;
        if (mem_ack) begin
            ack_cnt       <= ack_cnt + 1;
            last_ack_addr <= mem_addr;
        end
    end

    // Zero-wait memory for the wrap instance.
    assign mem_ack_w  = mem_req_w;
    assign mem_data_w = mem_word(mem_addr_w);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream model: the consumer must see consecutive PCs from the restart
    // point (reset or redirect target), each with its memory word; nothing
    // is visible the cycle after a redirect; an un-acked address is held.
    logic [31:0] exp_pc;
    logic        redir_prev;
    logic        hold_vld;
    logic [31:0] hold_addr;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc     = 32'h0;
            redir_prev = 1'b0;
            hold_vld   = 1'b0;
            hold_addr  = 32'h0;
        end else begin
            if (redir_prev) begin
                chk("model_valid_after_redirect", {31'b0, valid}, 32'd0);
            end else if (valid) begin
                chk("model_pc", pc, exp_pc);
                chk("model_instr", instr, mem_word(exp_pc));
                chk("model_pc_plus4", pc_plus4, exp_pc + 32'd4);
            end
            if (hold_vld && mem_req) chk("model_addr_hold", mem_addr, hold_addr);
            hold_vld  = mem_req && !mem_ack;
            hold_addr = mem_addr;
            if (redirect)            exp_pc = redirect_pc & 32'hFFFF_FFFC;
            else if (valid && ready) exp_pc = exp_pc + 32'd4;
            redir_prev = redirect;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          a0;
        logic [31:0] acked_addr;

        rst_n = 1'b1; rst_w_n = 1'b1;
        redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
        redirect_w = 1'b0; redirect_pc_w = 32'h0; ready_w = 1'b1;
        #2;
        rst_n = 1'b0; rst_w_n = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_w_addr", mem_addr_w, 32'hFFFF_FFF8);
        chk("rst_w_pc_plus4", pc_plus4_w, 32'h4);

        // Stream, zero-wait memory, ready=1
        rst_n = 1'b1;
        tick();
        chk("stream_req_c1", {31'b0, mem_req}, 32'd1);
        chk("stream_addr_c1", mem_addr, 32'h0);
        chk("stream_valid_c1", {31'b0, valid}, 32'd0);
        tick();
        chk("stream_valid_c2", {31'b0, valid}, 32'd1);
        chk("stream_pc0", pc, 32'h0);
        chk("stream_instr0", instr, 32'hECA8_9BDF);
        chk("stream_pc_plus4_0", pc_plus4, 32'h4);
        tick(); chk("stream_pc4", pc, 32'h4);
        tick(); chk("stream_pc8", pc, 32'h8);
        tick(); chk("stream_pcC", pc, 32'hC);
        chk("stream_pc_plus4_C", pc_plus4, 32'h10);

        // Backpressure; a stray ack right after reset release is ignored
        ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        chk("bp_req_c1", {31'b0, mem_req}, 32'd1);
        chk("bp_addr_c1", mem_addr, 32'h0);
        a0 = ack_cnt;
        for (int i = 0; i < 8; i++) tick();
        chk("bp_ack_count", 32'(ack_cnt - a0), 32'd4);
        chk("bp_last_addr", last_ack_addr, 32'hC);
        chk("bp_req_idle", {31'b0, mem_req}, 32'd0);
        chk("bp_head_pc", pc, 32'h0);
        ack_force = 1'b1;          // stray ack while IDLE with a full FIFO
        tick();
        ack_force = 1'b0;
        chk("bp_stray_req", {31'b0, mem_req}, 32'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("bp_pop_pc", pc, 32'h4);
        a0 = ack_cnt;
        for (int i = 0; i < 6; i++) tick();
        chk("bp_refill_count", 32'(ack_cnt - a0), 32'd1);
        chk("bp_refill_addr", last_ack_addr, 32'h10);
        chk("bp_refill_idle", {31'b0, mem_req}, 32'd0);

        // Redirect in IDLE with a full FIFO
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("ri_valid", {31'b0, valid}, 32'd0);
        chk("ri_req_idle", {31'b0, mem_req}, 32'd0);
        tick();
        chk("ri_req", {31'b0, mem_req}, 32'd1);
        chk("ri_addr", mem_addr, 32'h100);
        tick();
        chk("ri_valid_up", {31'b0, valid}, 32'd1);
        chk("ri_pc", pc, 32'h100);

        // Redirect while a 3-cycle read to 0x8 is outstanding
        ready = 1'b1; lat = 3;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        while (!(mem_req && mem_addr == 32'h8) && n < 40) begin tick(); n++; end
        chk("ro_reach_8", {31'b0, n < 40}, 32'd1);
        tick();
        redirect = 1'b1; redirect_pc = 32'h202;
        tick();
        redirect = 1'b0;
        n = 0;
        while (mem_req && n < 10) begin
            chk("ro_addr_held", mem_addr, 32'h8);
            tick(); n++;
        end
        chk("ro_discard_done", {31'b0, n < 10}, 32'd1);
        n = 0;
        while (!mem_req && n < 5) begin tick(); n++; end
        chk("ro_next_addr", mem_addr, 32'h200);
        n = 0;
        while (!valid && n < 10) begin tick(); n++; end
        chk("ro_first_pc", pc, 32'h200);

        // Redirect coincident with an ack
        n = 0;
        while (!mem_ack && n < 20) begin tick(); n++; end
        chk("co_ack_seen", {31'b0, n < 20}, 32'd1);
        acked_addr = mem_addr;
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk("co_valid", {31'b0, valid}, 32'd0);
        chk("co_idle", {31'b0, mem_req}, 32'd0);
        n = 0;
        while (!mem_req && n < 5) begin tick(); n++; end
        chk("co_next_addr", mem_addr, 32'h40);
        chk("co_acked_not_next", {31'b0, acked_addr == 32'h40}, 32'd0);
        n = 0;
        while (!valid && n < 10) begin tick(); n++; end
        chk("co_first_pc", pc, 32'h40);

        // PC wrap and asynchronous reset on the RESET_PC=0xFFFF_FFF8 instance
        rst_w_n = 1'b1;
        tick();
        chk("wr_req", {31'b0, mem_req_w}, 32'd1);
        chk("wr_addr", mem_addr_w, 32'hFFFF_FFF8);
        tick();
        chk("wr_pc0", pc_w, 32'hFFFF_FFF8);
        chk("wr_p4_0", pc_plus4_w, 32'hFFFF_FFFC);
        chk("wr_instr0", instr_w, mem_word(32'hFFFF_FFF8));
        tick();
        chk("wr_pc1", pc_w, 32'hFFFF_FFFC);
        chk("wr_p4_1", pc_plus4_w, 32'h0);
        tick();
        chk("wr_pc2", pc_w, 32'h0);
        chk("wr_p4_2", pc_plus4_w, 32'h4);
        chk("wr_pre_rst_req", {31'b0, mem_req_w}, 32'd1);
        #2;
        rst_w_n = 1'b0;
        #1;
        chk("wr_async_req", {31'b0, mem_req_w}, 32'd0);
        chk("wr_async_valid", {31'b0, valid_w}, 32'd0);
        chk("wr_async_addr", mem_addr_w, 32'hFFFF_FFF8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
